// File: rtl/mem_pkg.sv
// Shared types and helpers for the MEM-stage data-memory access unit.
package mem_pkg;

    localparam int unsigned LANES = 4;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'b00,
        MEM_HALF = 2'b01,
        MEM_WORD = 2'b10
    } mem_size_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        DONE = 2'b10
    } mem_state_e;

    // The raw size field encodes word as both 2'b10 and 2'b11.
    function automatic mem_size_e decode_size(logic [1:0] size);
        mem_size_e res;
        case (size)
            2'b00:   res = MEM_BYTE;
            2'b01:   res = MEM_HALF;
            default: res = MEM_WORD;
        endcase
        return res;
    endfunction

    function automatic logic [LANES-1:0] byte_en(mem_size_e size, logic [1:0] addr_lo);
        logic [LANES-1:0] res;
        case (size)
            MEM_BYTE: res = 4'b0001 << addr_lo;
            MEM_HALF: res = 4'b0011 << {addr_lo[1], 1'b0};
            default:  res = 4'b1111;
        endcase
        return res;
    endfunction

    function automatic logic [31:0] lane_replicate(mem_size_e size, logic [31:0] data);
        logic [31:0] res;
        case (size)
            MEM_BYTE: res = {4{data[7:0]}};
            MEM_HALF: res = {2{data[15:0]}};
            default:  res = data;
        endcase
        return res;
    endfunction

    function automatic logic misaligned(mem_size_e size, logic [1:0] addr_lo);
        logic res;
        case (size)
            MEM_BYTE: res = 1'b0;
            MEM_HALF: res = addr_lo[0];
            default:  res = |addr_lo;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load-data alignment: selects the addressed lane(s) of the read word and sign/zero-extends.
module mem_load_align
    import mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] load_data
);

    logic [1:0]  lane;
    logic [31:0] shifted;
    logic        sx;

    // Low address bits that do not belong to the access size are ignored.
    always_comb begin
        lane      = 2'b00;
        shifted   = '0;
        load_data = '0;
        sx        = ~is_unsigned;
        case (decode_size(size))
            MEM_BYTE: lane = addr_lo;
            MEM_HALF: lane = {addr_lo[1], 1'b0};
            default:  lane = 2'b00;
        endcase
        shifted = rdata >> {lane, 3'b000};
        case (decode_size(size))
            MEM_BYTE: load_data = {{24{sx & shifted[7]}}, shifted[7:0]};
            MEM_HALF: load_data = {{16{sx & shifted[15]}}, shifted[15:0]};
            default:  load_data = shifted;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM-stage data-memory access unit: req/ready handshake, pipeline stall, aligned load data.
// Optional misaligned-access trap enabled by defining MEM_MISALIGN_TRAP_EN.
module mem_access_stage
    import mem_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [1:0]        size,
    input  logic              load_unsigned,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] store_data,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    output logic [3:0]        dmem_be,
    input  logic              dmem_ready,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic [DATA_W-1:0] load_data,
    output logic              data_valid,
    output logic              stall,
    output logic              bus_err,
    output logic              misalign_err
);

    localparam logic [1:0] S_IDLE = 2'(IDLE);
    localparam logic [1:0] S_REQ  = 2'(REQ);
    localparam logic [1:0] S_DONE = 2'(DONE);

    localparam int unsigned CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam bit          TO_EN    = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [1:0]        state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [DATA_W-1:0] load_nxt;
    logic              bus_flag, bus_nxt;
    logic              capture;
    logic              launch;
    logic              mis_in;
    mem_size_e         in_size;

    logic [ADDR_W-1:0] req_addr;
    logic [1:0]        req_lo;
    logic              req_we;
    mem_size_e         req_size;
    logic              req_uns;
    logic [3:0]        req_be;
    logic [DATA_W-1:0] req_wdata;
    logic [DATA_W-1:0] aligned;

    assign in_size = decode_size(size);
    assign launch  = in_valid & (mem_read | mem_write);

`ifdef MEM_MISALIGN_TRAP_EN
    logic mis_flag;

    assign mis_in = misaligned(in_size, addr[1:0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            mis_flag <= 1'b0;
        end else if (capture) begin
            mis_flag <= mis_in;
        end
    end

    assign misalign_err = data_valid & mis_flag;
`else
    assign mis_in       = 1'b0;
    assign misalign_err = 1'b0;
`endif

    mem_load_align u_align (
        .rdata       (dmem_rdata),
        .addr_lo     (req_lo),
        .size        (req_size),
        .is_unsigned (req_uns),
        .load_data   (aligned)
    );

    // Next-state and completion data; ready on the last timeout cycle still completes cleanly.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        load_nxt  = load_data;
        bus_nxt   = bus_flag;
        capture   = 1'b0;
        case (state)
            S_IDLE: begin
                if (launch) begin
                    capture = 1'b1;
                    cnt_nxt = '0;
                    bus_nxt = 1'b0;
                    if (mis_in) begin
                        load_nxt  = '0;
                        state_nxt = S_DONE;
                    end else begin
                        state_nxt = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (dmem_ready) begin
                    load_nxt  = req_we ? '0 : aligned;
                    state_nxt = S_DONE;
                end else if (TO_EN && (cnt == CNT_LAST)) begin
                    load_nxt  = '0;
                    bus_nxt   = 1'b1;
                    state_nxt = S_DONE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            load_data <= '0;
            bus_flag  <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            load_data <= load_nxt;
            bus_flag  <= bus_nxt;
        end
    end

    // Request fields are frozen at launch and held for the whole handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_addr  <= '0;
            req_lo    <= 2'b00;
            req_we    <= 1'b0;
            req_size  <= MEM_BYTE;
            req_uns   <= 1'b0;
            req_be    <= 4'b0000;
            req_wdata <= '0;
        end else if (capture) begin
            req_addr  <= {addr[ADDR_W-1:2], 2'b00};
            req_lo    <= addr[1:0];
            req_we    <= mem_write;
            req_size  <= in_size;
            req_uns   <= load_unsigned;
            req_be    <= byte_en(in_size, addr[1:0]);
            req_wdata <= lane_replicate(in_size, store_data);
        end
    end

    assign dmem_req   = (state == S_REQ);
    assign dmem_we    = dmem_req & req_we;
    assign dmem_addr  = req_addr;
    assign dmem_wdata = req_wdata;
    assign dmem_be    = req_be;
    assign data_valid = (state == S_DONE);
    assign bus_err    = data_valid & bus_flag;
    assign stall      = ((state == S_IDLE) & launch) | (state == S_REQ);

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: random ops against a byte-level reference model.
module tb_mem_access_stage;

    localparam int unsigned TIMEOUT = 16;
    localparam int          NEVER   = 1000;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          delay;
    } req_t;

    typedef struct {
        logic [31:0] ld;
        logic        berr;
        logic        merr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, mem_read, mem_write, load_unsigned;
    logic [1:0]  size;
    logic [31:0] addr, store_data;
    logic        dmem_req, dmem_we, dmem_ready;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata, load_data;
    logic [3:0]  dmem_be;
    logic        data_valid, stall, bus_err, misalign_err;

    req_t req_q[$];
    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    mem_access_stage #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(TIMEOUT)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .size          (size),
        .load_unsigned (load_unsigned),
        .addr          (addr),
        .store_data    (store_data),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .dmem_addr     (dmem_addr),
        .dmem_wdata    (dmem_wdata),
        .dmem_be       (dmem_be),
        .dmem_ready    (dmem_ready),
        .dmem_rdata    (dmem_rdata),
        .load_data     (load_data),
        .data_valid    (data_valid),
        .stall         (stall),
        .bus_err       (bus_err),
        .misalign_err  (misalign_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: accesses described as n bytes starting at a byte offset in the word.
    function automatic int nbytes(logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic int lane_off(logic [1:0] sz, logic [31:0] a);
        int n = nbytes(sz);
        return ((int'(a % 4)) / n) * n;
    endfunction

    function automatic logic [3:0] ref_be(logic [1:0] sz, logic [31:0] a);
        int n = nbytes(sz);
        int off = lane_off(sz, a);
        logic [3:0] be = '0;
        for (int i = 0; i < 4; i++) be[i] = (i >= off) && (i < off + n);
        return be;
    endfunction

    function automatic logic [31:0] ref_wdata(logic [1:0] sz, logic [31:0] d);
        int n = nbytes(sz);
        logic [31:0] w = '0;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % n) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] ref_load(logic [31:0] rd, logic [1:0] sz, logic uns, logic [31:0] a);
        int n = nbytes(sz);
        int off = lane_off(sz, a);
        longint v = 0;
        for (int j = 0; j < n; j++) v += longint'(rd[8*(off+j) +: 8]) << (8*j);
        if (!uns && v >= (longint'(1) << (8*n - 1))) v -= longint'(1) << (8*n);
        return 32'(v);
    endfunction

    // Issue one EX/MEM instruction, queue its expectations and hold it until stall drops.
    task automatic run_op(input logic iv, input logic rd, input logic wr, input logic [1:0] sz,
                          input logic uns, input logic [31:0] a, input logic [31:0] sd,
                          input logic [31:0] rdat, input int delay);
        int   n_st, exp_st;
        bit   launch, mis, tmo;
        req_t r;
        exp_t e;
        launch = iv && (rd || wr);
        mis    = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
        mis = launch && ((int'(a % 4) % nbytes(sz)) != 0);
`endif
        @(posedge clk); #1;
        in_valid = iv; mem_read = rd; mem_write = wr; size = sz;
        load_unsigned = uns; addr = a; store_data = sd;
        if (!launch) begin
            exp_st = 0;
        end else if (mis) begin
            e.ld = '0; e.berr = 1'b0; e.merr = 1'b1;
            exp_q.push_back(e);
            exp_st = 1;
        end else begin
            tmo     = delay >= int'(TIMEOUT);
            r.addr  = a & ~32'h3;
            r.we    = wr;
            r.be    = ref_be(sz, a);
            r.wdata = ref_wdata(sz, sd);
            r.rdata = rdat;
            r.delay = delay;
            req_q.push_back(r);
            e.ld   = (tmo || wr) ? 32'h0 : ref_load(rdat, sz, uns, a);
            e.berr = tmo;
            e.merr = 1'b0;
            exp_q.push_back(e);
            exp_st = 1 + (tmo ? int'(TIMEOUT) : delay + 1);
        end
        n_st = 0;
        forever begin
            @(negedge clk);
            if (!stall) break;
            n_st++;
            if (n_st > 60) break;
        end
        chk("stall_cycles", n_st, exp_st);
    endtask

    // Memory model: checks each new request, answers after the queued delay, babbles when idle.
    initial begin
        bit   active;
        int   k;
        req_t cur;
        active = 0; k = 0; cur.delay = NEVER;
        dmem_ready = 1'b0; dmem_rdata = '0;
        forever begin
            @(negedge clk);
            if (dmem_req) begin
                if (!active) begin
                    active = 1; k = 0;
                    if (req_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_req: got req at addr %0h expected none", dmem_addr);
                        cur.delay = NEVER;
                    end else begin
                        cur = req_q.pop_front();
                        chk("dmem_addr", dmem_addr, cur.addr);
                        chk("dmem_we", 32'(dmem_we), 32'(cur.we));
                        chk("dmem_be", 32'(dmem_be), 32'(cur.be));
                        if (cur.we) chk("dmem_wdata", dmem_wdata, cur.wdata);
                    end
                end else begin
                    k++;
                end
                dmem_ready = (k == cur.delay);
                dmem_rdata = (k == cur.delay) ? cur.rdata : $urandom;
            end else begin
                active     = 0;
                dmem_ready = ($urandom_range(0, 3) == 0);
                dmem_rdata = $urandom;
            end
        end
    end

    // Completion monitor.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (data_valid) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_data_valid: got load_data %0h expected no completion", load_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("load_data", load_data, e.ld);
                    chk("bus_err", 32'(bus_err), 32'(e.berr));
                    chk("misalign_err", 32'(misalign_err), 32'(e.merr));
                end
            end else if (bus_err || misalign_err) begin
                chk("err_without_valid", {30'd0, bus_err, misalign_err}, 32'h0);
            end
        end
    end

    task automatic reset_in_req();
        req_t r;
        @(posedge clk); #1;
        in_valid = 1; mem_read = 1; mem_write = 0; size = 2'd2; addr = 32'h200;
        r.addr = 32'h200; r.we = 0; r.be = 4'hF; r.wdata = '0; r.rdata = '0; r.delay = NEVER;
        req_q.push_back(r);
        repeat (3) @(negedge clk);
        chk("req_before_rst", 32'(dmem_req), 32'h1);
        @(posedge clk); #1;
        rst = 1; in_valid = 0;
        repeat (2) @(negedge clk);
        chk("rst_dmem_req", 32'(dmem_req), 32'h0);
        chk("rst_stall", 32'(stall), 32'h0);
        chk("rst_data_valid", 32'(data_valid), 32'h0);
        chk("rst_load_data", load_data, 32'h0);
        @(posedge clk); #1;
        rst = 0;
    endtask

    initial begin
        logic [1:0]  sz;
        logic [31:0] a;
        int          kind, dly;
        rst = 1; in_valid = 0; mem_read = 0; mem_write = 0; size = 0;
        load_unsigned = 0; addr = 0; store_data = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_dmem_req", 32'(dmem_req), 32'h0);
        chk("reset_dmem_we", 32'(dmem_we), 32'h0);
        chk("reset_dmem_addr", dmem_addr, 32'h0);
        chk("reset_dmem_wdata", dmem_wdata, 32'h0);
        chk("reset_dmem_be", 32'(dmem_be), 32'h0);
        chk("reset_load_data", load_data, 32'h0);
        chk("reset_data_valid", 32'(data_valid), 32'h0);
        chk("reset_stall", 32'(stall), 32'h0);
        chk("reset_bus_err", 32'(bus_err), 32'h0);
        chk("reset_misalign_err", 32'(misalign_err), 32'h0);
        @(posedge clk); #1;
        rst = 0;

        run_op(1, 0, 1, 2'd2, 0, 32'h100, 32'hDEADBEEF, 32'h0, 1);          // sw, 3 stall cycles
        run_op(1, 1, 0, 2'd0, 0, 32'h103, 32'h0, 32'h80FF0000, 0);          // lb -> FFFFFF80
        run_op(1, 1, 0, 2'd0, 1, 32'h103, 32'h0, 32'h80FF0000, 2);          // lbu -> 00000080
        reset_in_req();
        run_op(1, 0, 1, 2'd1, 0, 32'h002, 32'h00001234, 32'h0, 0);          // sh, be 1100
        run_op(1, 1, 0, 2'd2, 0, 32'h040, 32'h0, 32'h12345678, NEVER);      // lw timeout
        run_op(1, 1, 0, 2'd2, 0, 32'h040, 32'h0, 32'h12345678, 15);         // ready on last cycle
        run_op(1, 1, 0, 2'd2, 0, 32'h101, 32'h0, 32'hCAFEF00D, 0);          // misaligned lw
        run_op(1, 1, 0, 2'd1, 0, 32'h105, 32'h0, 32'h8001FFFF, 1);          // misaligned lh
        run_op(1, 1, 1, 2'd3, 0, 32'h10C, 32'hA5A55A5A, 32'h0, 0);          // both set: store wins
        run_op(1, 0, 0, 2'd2, 0, 32'h10C, 32'h0, 32'h0, 0);                 // non-memory op

        for (int i = 0; i < 250; i++) begin
            sz   = 2'($urandom_range(0, 3));
            kind = $urandom_range(0, 9);
            dly  = ($urandom_range(0, 9) == 0) ? NEVER : $urandom_range(0, 4);
            a    = $urandom & 32'h0000_0FFF;
            case (kind)
                0:       run_op(0, 1'($urandom), 1'($urandom), sz, 0, a, $urandom, $urandom, dly);
                1:       run_op(1, 0, 0, sz, 0, a, $urandom, $urandom, dly);
                2, 3, 4, 5: run_op(1, 1, 0, sz, 1'($urandom), a, $urandom, $urandom, dly);
                6, 7, 8: run_op(1, 0, 1, sz, 1'($urandom), a, $urandom, $urandom, dly);
                default: run_op(1, 1, 1, sz, 1'($urandom), a, $urandom, $urandom, dly);
            endcase
        end

        @(posedge clk); #1;
        in_valid = 0;
        repeat (4) @(negedge clk);
        chk("exp_queue_drained", 32'(exp_q.size()), 32'h0);
        chk("req_queue_drained", 32'(req_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test by %0t expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
